// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. Receives a framed program image (length,
//               payload, checksum) from a byte stream and writes it into RAM
//               starting at BASE_ADDR. It then reads the image back to verify
//               it, and finally releases the CPU and hands the RAM port over.
//               While the CPU is not running, the loader owns the RAM bus.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cpu_ram_data,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic              cpu_ram_we,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error
);

  // The length byte encodes 1..2**DATA_W (0 stands for 2**DATA_W), so the
  // length and byte counters need one extra bit.
  localparam int unsigned       CNT_W      = DATA_W + 1;
  localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ZERO = '0;

  typedef enum logic [2:0] {
    S_WAIT_LEN = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_SUM = 3'd2,
    S_VERIFY   = 3'd3,
    S_RUN      = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_len;        // number of payload bytes in the frame
  logic [CNT_W-1:0]   r_cnt;        // payload bytes accepted / verify cycles
  logic [DATA_W-1:0]  r_rsum;       // running checksum of received payload
  logic [DATA_W-1:0]  r_vsum;       // checksum of the image read back
  logic [ADDR_W-1:0]  r_ptr;        // next RAM address for a payload write
  logic [ADDR_W-1:0]  r_addr;       // loader-side RAM address
  logic [DATA_W-1:0]  r_data;       // loader-side RAM write data
  logic               r_we;         // loader-side RAM write enable
  logic               r_in_ready;
  logic               r_cpu_run;
  logic               r_load_done;
  logic               r_load_error;

  logic               w_xfer;
  logic [CNT_W-1:0]   w_len_in;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [DATA_W-1:0]  w_vsum_next;

  assign w_xfer      = in_valid & r_in_ready;
  assign w_len_in    = {(in_data == '0), in_data};
  assign w_cnt_inc   = r_cnt + C_CNT_ONE;
  assign w_vsum_next = r_vsum + ram_out;

  // Loader state machine: framing, payload writes, readback verify, hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT_LEN;
      r_len        <= '0;
      r_cnt        <= '0;
      r_rsum       <= '0;
      r_vsum       <= '0;
      r_ptr        <= C_BASE;
      r_addr       <= C_BASE;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_in_ready   <= 1'b1;
      r_cpu_run    <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      // A write strobe lasts exactly one cycle per accepted payload byte.
      r_we <= 1'b0;
      case (r_state)
        S_WAIT_LEN: begin
          if (w_xfer) begin
            r_len   <= w_len_in;
            r_cnt   <= '0;
            r_rsum  <= '0;
            r_ptr   <= C_BASE;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Byte is registered here and written to RAM in the next cycle.
          if (w_xfer) begin
            r_we   <= 1'b1;
            r_addr <= r_ptr;
            r_data <= in_data;
            r_ptr  <= r_ptr + C_ADDR_ONE;
            r_rsum <= r_rsum + in_data;
            r_cnt  <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_state <= S_WAIT_SUM;
            end
          end
        end

        S_WAIT_SUM: begin
          // The last payload write is in flight during the first cycle here.
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == r_rsum) begin
              r_state <= S_VERIFY;
              r_cnt   <= '0;
              r_vsum  <= '0;
              r_addr  <= C_BASE;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end

        S_VERIFY: begin
          // Cycle k presents address BASE+k; the byte returned for the
          // previous address is accumulated, so len reads take len+1 cycles.
          r_addr <= r_addr + C_ADDR_ONE;
          r_cnt  <= w_cnt_inc;
          if (r_cnt != C_CNT_ZERO) begin
            r_vsum <= w_vsum_next;
          end
          if (r_cnt == r_len) begin
            if (w_vsum_next == r_rsum) begin
              r_state     <= S_RUN;
              r_cpu_run   <= 1'b1;
              r_load_done <= 1'b1;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end

        S_RUN, S_ERROR: begin
          // A start pulse takes the bus back and re-arms the loader.
          if (start) begin
            r_state      <= S_WAIT_LEN;
            r_cpu_run    <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_in_ready   <= 1'b1;
            r_cnt        <= '0;
            r_addr       <= C_BASE;
          end
        end

        default: begin
          r_state    <= S_WAIT_LEN;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // RAM bus belongs to the CPU only while it runs; otherwise the loader drives it.
  assign ram_data   = r_cpu_run ? cpu_ram_data : r_data;
  assign ram_addr   = r_cpu_run ? cpu_ram_addr : r_addr;
  assign ram_we     = r_cpu_run ? cpu_ram_we   : r_we;

  assign in_ready   = r_in_ready;
  assign cpu_run    = r_cpu_run;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Two instances share
//               one input stream (BASE_ADDR 0x00 and 0xFE), each with its own
//               RAM model. Expected writes and outcomes are queued by the
//               stimulus and popped by a monitor on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  typedef struct packed {
    logic        run;
    logic [31:0] at;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] cpu_ram_data;
  logic [7:0] cpu_ram_addr;
  logic       cpu_ram_we;
  logic       bd_req;

  logic       in_ready0, ram_we0, cpu_run0, load_done0, load_error0;
  logic [7:0] ram_out0, ram_data0, ram_addr0;
  logic       in_ready1, ram_we1, cpu_run1, load_done1, load_error1;
  logic [7:0] ram_out1, ram_data1, ram_addr1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  logic [15:0] wq0[$];
  logic [15:0] wq1[$];
  out_t        oq0[$];
  out_t        oq1[$];
  logic        pd0, pe0, pd1, pe1;

  program_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .cpu_ram_data(cpu_ram_data), .cpu_ram_addr(cpu_ram_addr), .cpu_ram_we(cpu_ram_we),
    .ram_out(ram_out0), .ram_data(ram_data0), .ram_addr(ram_addr0), .ram_we(ram_we0),
    .cpu_run(cpu_run0), .load_done(load_done0), .load_error(load_error0)
  );

  program_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(254)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .cpu_ram_data(cpu_ram_data), .cpu_ram_addr(cpu_ram_addr), .cpu_ram_we(cpu_ram_we),
    .ram_out(ram_out1), .ram_data(ram_data1), .ram_addr(ram_addr1), .ram_we(ram_we1),
    .cpu_run(cpu_run1), .load_done(load_done1), .load_error(load_error1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM models (read data one cycle after the address) with a
  // backdoor that inverts the second image byte of each instance.
  always @(posedge clk) begin
    if (ram_we0) mem0[ram_addr0] <= ram_data0;
    if (ram_we1) mem1[ram_addr1] <= ram_data1;
    if (bd_req) begin
      mem0[8'h01] <= ~mem0[8'h01];
      mem1[8'hFF] <= ~mem1[8'hFF];
    end
    ram_out0 <= mem0[ram_addr0];
    ram_out1 <= mem1[ram_addr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_write(input int k, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] e;
    bit          have;
    e = '0;
    if (k == 0) begin
      have = (wq0.size() != 0);
      if (have) e = wq0.pop_front();
    end else begin
      have = (wq1.size() != 0);
      if (have) e = wq1.pop_front();
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL wr%0d unexpected: got addr=%h data=%h expected no write", k, a, d);
    end else if ({a, d} !== e) begin
      errors++;
      $display("FAIL wr%0d: got addr=%h data=%h expected addr=%h data=%h", k, a, d, e[15:8], e[7:0]);
    end
  endtask

  task automatic mon_out(input int k, input logic run);
    out_t e;
    bit   have;
    e = '0;
    if (k == 0) begin
      have = (oq0.size() != 0);
      if (have) e = oq0.pop_front();
    end else begin
      have = (oq1.size() != 0);
      if (have) e = oq1.pop_front();
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL out%0d unexpected: got run=%0d at cycle %0d expected no outcome", k, run, cyc);
    end else if (run !== e.run || cyc !== int'(e.at)) begin
      errors++;
      $display("FAIL out%0d: got run=%0d at cycle %0d expected run=%0d at cycle %0d",
               k, run, cyc, e.run, e.at);
    end
  endtask

  // Monitor: pops expected writes and outcomes as the DUTs present them.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we0 && !cpu_run0) mon_write(0, ram_addr0, ram_data0);
      if (ram_we1 && !cpu_run1) mon_write(1, ram_addr1, ram_data1);
      if (load_done0 && !pd0)  mon_out(0, 1'b1);
      if (load_error0 && !pe0) mon_out(0, 1'b0);
      if (load_done1 && !pd1)  mon_out(1, 1'b1);
      if (load_error1 && !pe1) mon_out(1, 1'b0);
    end
    pd0 <= load_done0;
    pe0 <= load_error0;
    pd1 <= load_done1;
    pe1 <= load_error1;
  end

  task automatic push_wr(input int i, input logic [7:0] d);
    logic [7:0] a0;
    logic [7:0] a1;
    a0 = 8'h00 + 8'(i);
    a1 = 8'hFE + 8'(i);
    wq0.push_back({a0, d});
    wq1.push_back({a1, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    n        = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got in_ready=0 for byte %h expected 1", b);
    end
  endtask

  // Sends len, payload and checksum; queues the writes and the outcome,
  // which is expected at_off cycles after the checksum is accepted.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] sum,
                            input int gap, input bit corrupt, input bit run, input int at_off);
    out_t o;
    send_byte(len);
    for (int i = 0; i < pl.size(); i++) begin
      push_wr(i, pl[i]);
      send_byte(pl[i]);
      for (int g = 0; g < gap; g++) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    if (corrupt) begin
      repeat (2) @(posedge clk);
      #1;
      bd_req = 1'b1;
      @(posedge clk);
      #1;
      bd_req = 1'b0;
    end
    send_byte(sum);
    o.run = run;
    o.at  = 32'(cyc + at_off);
    oq0.push_back(o);
    oq1.push_back(o);
  endtask

  task automatic wait_outcome();
    int n;
    n = 0;
    while ((oq0.size() != 0 || oq1.size() != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (oq0.size() != 0 || oq1.size() != 0) begin
      errors++;
      $display("FAIL outcome_timeout: got %0d/%0d pending expected 0", oq0.size(), oq1.size());
      oq0.delete();
      oq1.delete();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] pl[$];
    rst          = 1'b1;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    cpu_ram_data = 8'h00;
    cpu_ram_addr = 8'h00;
    cpu_ram_we   = 1'b0;
    bd_req       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_run",    {31'd0, cpu_run0},    32'd0);
    check("rst_load_done",  {31'd0, load_done0},  32'd0);
    check("rst_load_error", {31'd0, load_error0}, 32'd0);
    check("rst_ram_we",     {31'd0, ram_we0},     32'd0);
    check("rst_ram_addr0",  {24'd0, ram_addr0},   32'h00);
    check("rst_ram_addr1",  {24'd0, ram_addr1},   32'hFE);
    check("rst_ram_data",   {24'd0, ram_data0},   32'h00);
    check("rst_in_ready",   {31'd0, in_ready1},   32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Good frame, back-to-back bytes.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, pl, 8'h66, 0, 1'b0, 1'b1, 4);
    wait_outcome();
    check("run_cpu_run",   {31'd0, cpu_run0},  32'd1);
    check("run_load_done", {31'd0, load_done1}, 32'd1);
    check("run_in_ready",  {31'd0, in_ready0}, 32'd0);
    check("ram0_0", {24'd0, mem0[8'h00]}, 32'h11);
    check("ram0_2", {24'd0, mem0[8'h02]}, 32'h33);
    check("ram1_ff", {24'd0, mem1[8'hFF]}, 32'h22);
    cpu_ram_addr = 8'h80;
    cpu_ram_data = 8'h5A;
    cpu_ram_we   = 1'b1;
    #1;
    check("mux_addr", {24'd0, ram_addr1}, 32'h80);
    check("mux_data", {24'd0, ram_data0}, 32'h5A);
    check("mux_we",   {31'd0, ram_we0},   32'd1);
    cpu_ram_we = 1'b0;
    #1;
    check("mux_we_off", {31'd0, ram_we1}, 32'd0);
    pulse_start();
    check("restart_in_ready", {31'd0, in_ready0}, 32'd1);
    check("restart_cpu_run",  {31'd0, cpu_run0},  32'd0);

    // Bad checksum.
    send_frame(8'd3, pl, 8'h67, 0, 1'b0, 1'b0, 0);
    wait_outcome();
    check("err_load_error", {31'd0, load_error0}, 32'd1);
    check("err_cpu_run",    {31'd0, cpu_run1},    32'd0);
    check("err_ram_we",     {31'd0, ram_we0},     32'd0);
    pulse_start();
    check("err_restart_ready", {31'd0, in_ready1},   32'd1);
    check("err_restart_flag",  {31'd0, load_error0}, 32'd0);

    // Gapped valid, start pulses during LOAD, base 0xFE wraps to 00,01.
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(8'd4, pl, 8'hEA, 1, 1'b0, 1'b1, 5);
    wait_outcome();
    check("wrap_ram1_00", {24'd0, mem1[8'h00]}, 32'hC3);
    check("wrap_ram1_01", {24'd0, mem1[8'h01]}, 32'hD4);
    pulse_start();

    // Image corrupted in RAM before verify.
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'd3, pl, 8'h06, 0, 1'b1, 1'b0, 4);
    wait_outcome();
    check("corrupt_error", {31'd0, load_error1}, 32'd1);
    pulse_start();

    // Reset in the middle of a 5-byte load.
    send_byte(8'd5);
    push_wr(0, 8'h10);
    send_byte(8'h10);
    send_byte(8'h20);
    check("mid_we_before_rst", {31'd0, ram_we0}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_we0",     {31'd0, ram_we0},    32'd0);
    check("mid_rst_we1",     {31'd0, ram_we1},    32'd0);
    check("mid_rst_ready",   {31'd0, in_ready0},  32'd1);
    check("mid_rst_addr1",   {24'd0, ram_addr1},  32'hFE);
    check("mid_rst_data0",   {24'd0, ram_data0},  32'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_frame(8'd5, pl, 8'hF0, 0, 1'b0, 1'b1, 6);
    wait_outcome();
    check("reload_done", {31'd0, load_done0}, 32'd1);
    check("ram1_reload", {24'd0, mem1[8'h02]}, 32'h50);

    repeat (2) @(posedge clk);
    check("wq0_empty", 32'(wq0.size()), 32'd0);
    check("wq1_empty", 32'(wq1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
